// File: rtl/axis_bulk_packetizer.sv
// Packetizes a continuous 8-bit AXI4-Stream into bulk-sized packets. The output
// packet ends at a MAX_PACKET boundary, on an upstream tlast, or on idle timeout
// or flush. One byte of lookahead (H) lets tlast always ride on a real data byte.
module axis_bulk_packetizer #(
  parameter int unsigned MAX_PACKET = 512,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  input  logic       s_axis_tlast_i,
  input  logic [7:0] s_axis_tdata_i,
  output logic       m_axis_tvalid_o,
  input  logic       m_axis_tready_i,
  output logic       m_axis_tlast_o,
  output logic [7:0] m_axis_tdata_o,
  input  logic       flush_i
);

  localparam int unsigned CntW  = $clog2(MAX_PACKET);
  // Keep at least one bit so TIMEOUT == 0 still elaborates.
  localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(MAX_PACKET - 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  // Hold register (lookahead byte)
  logic            r_hv;
  logic [7:0]      r_hd;
  logic            r_hterm;
  // Output register driving the master port
  logic            r_ov;
  logic [7:0]      r_od;
  logic            r_olast;
  logic [CntW-1:0]  r_cnt;
  logic [IdleW-1:0] r_idle;

  logic            w_o_free;
  logic            w_timeout;
  logic            w_close;
  logic            w_h_move;
  logic            w_accept;
  logic [CntW-1:0] w_base;
  logic            w_term;

  assign w_o_free  = !r_ov || m_axis_tready_i;
  assign w_timeout = (TIMEOUT != 0) && (r_idle == IdleMax);
  assign w_close   = r_hv && !r_hterm && (flush_i || w_timeout);
  // Uses tvalid rather than the input handshake, so no combinational loop.
  assign w_h_move  = r_hv && w_o_free && (r_hterm || s_axis_tvalid_i || w_close);
  assign s_axis_tready_o = !r_hv || w_h_move;
  assign w_accept  = s_axis_tvalid_i && s_axis_tready_o;

  // A closing packet makes the incoming byte index 0 of the next packet.
  assign w_base = w_close ? '0 : r_cnt;
  assign w_term = (w_base == CntLast) || s_axis_tlast_i;

  assign m_axis_tvalid_o = r_ov;
  assign m_axis_tdata_o  = r_od;
  assign m_axis_tlast_o  = r_olast;

  // Hold register: load on accept, drain when its byte moves to O.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_hv    <= 1'b0;
      r_hd    <= 8'h00;
      r_hterm <= 1'b0;
    end else if (w_accept) begin
      r_hv    <= 1'b1;
      r_hd    <= s_axis_tdata_i;
      r_hterm <= w_term;
    end else if (w_h_move) begin
      r_hv    <= 1'b0;
    end
  end

  // Output register: take the H byte, or empty on a downstream handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ov    <= 1'b0;
      r_od    <= 8'h00;
      r_olast <= 1'b0;
    end else if (w_h_move) begin
      r_ov    <= 1'b1;
      r_od    <= r_hd;
      r_olast <= r_hterm || w_close;
    end else if (r_ov && m_axis_tready_i) begin
      r_ov    <= 1'b0;
    end
  end

  // Byte index within the packet of the next accepted byte.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_term ? '0 : w_base + 1'b1;
    end else if (w_h_move && w_close) begin
      r_cnt <= '0;
    end
  end

  // Saturating idle counter for a pending non-terminating byte.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idle <= '0;
    end else if (w_accept || w_h_move) begin
      r_idle <= '0;
    end else if (r_hv && !r_hterm && !s_axis_tvalid_i && (r_idle != IdleMax)) begin
      r_idle <= r_idle + 1'b1;
    end
  end

endmodule
